sr_reg_bank: RTL and testbench
==============================

Name: sr_reg_bank

Overview:
- Parametrised, clocked successor to the team's single-bit enabled SR latch.
- Holds WIDTH independent SR storage bits that update synchronously on clk under a shared enable.
- The s=r=1 case is resolved deterministically by a compile-time MODE instead of driving X.
- Tracks collisions with a sticky error flag and a saturating counter, and reports per-bit change pulses; sits wherever lab designs need flag or status storage.

Parameters:
- WIDTH, 8, number of SR channels (≥1).
- MODE, 0, s=r=1 resolution: 0 reset-dominant (q←0), 1 set-dominant (q←1), 2 toggle (q←~q), 3 hold (q←q).
- CNT_W, 4, width of the collision counter (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- e  input  1  enable; when 0, all channels hold.
- s  input  WIDTH  per-channel set request.
- r  input  WIDTH  per-channel reset request.
- clr_err  input  1  synchronous clear of err and err_cnt.
- q  output  WIDTH  stored state.
- q_n  output  WIDTH  bitwise complement of q (combinational from q).
- chg  output  WIDTH  one-cycle pulse per bit that changed on the previous edge.
- err  output  1  sticky collision flag.
- err_cnt  output  CNT_W  saturating count of collision cycles.

Behaviour:
- Reset: on an edge with rst=1, q=0, chg=0, err=0, err_cnt=0. q_n therefore reads all-ones. rst overrides e, s, r and clr_err.
- Latency: inputs sampled at edge k appear on q after edge k (1 cycle). No combinational path from s, r or e to q.
- Per-channel next state when e=1, with s[i],r[i]:
  - 00 → hold.
  - 01 → 0.
  - 10 → 1.
  - 11 → per MODE.
- When e=0, every channel holds regardless of s and r, and no collision is recorded.
- Collision cycle: e=1 and (s & r) != 0. Any number of colliding bits counts as one event.
- err: set to 1 on the edge following a collision cycle; stays 1 until rst or clr_err.
- err_cnt: increments by 1 per collision cycle and saturates at 2^CNT_W−1 (no wrap).
- clr_err with a simultaneous collision: the clear applies first, then the event is counted, giving err=1, err_cnt=1. clr_err with no collision gives err=0, err_cnt=0.
- chg: registered; chg[i]=1 for exactly the cycle after an edge where q[i] changed, otherwise 0.
  - Toggle mode with a held 11 input gives chg[i]=1 every cycle.
  - A set or reset that does not change q (e.g. set while already 1) does not pulse chg.
- rst asserted mid-operation: state is lost on that edge; chg does not pulse for the reset-induced change. The first post-reset edge behaves normally.
- Illegal MODE values (>3) are a compile-time error.

Decomposition:
- Shared package: MODE encodings as named constants (RESET_DOM=0, SET_DOM=1, TOGGLE=2, HOLD=3).
- Sub-module sr_cell, one channel:
  - Inputs: clk, rst, e, s, r. Parameter MODE.
  - Outputs: q, chg.
- Instantiated WIDTH times via generate. The collision detect and counter live in the top level.

Test Plan:
- Reset, then e=1, s=8'h0F, r=0 → after 1 edge q=8'h0F, q_n=8'hF0, chg=8'h0F; next cycle chg=0.
- e=0, s=8'hFF, r=8'hFF for 3 cycles → q unchanged, chg=0, err=0, err_cnt=0.
- MODE=0/1/2/3 each with q=8'hA5, e=1, s=r=8'h01 → q[0] becomes 0/1/0/1 respectively (toggle: 1→0; hold: stays 1). err=1 and err_cnt=1 in every mode.
- CNT_W=4, 20 consecutive collision cycles → err_cnt saturates at 15; then clr_err with no collision → err=0, err_cnt=0; clr_err plus collision → err=1, err_cnt=1.
- q=8'hFF, rst pulsed while e=1, s=8'hFF → after the edge q=0, chg=0, err=0; next edge q=8'hFF, chg=8'hFF.
- MODE=2, s=r=8'h80 held 4 cycles → q[7] alternates 1,0,1,0; chg[7]=1 each cycle; err_cnt=4.

Source files
------------

// File: rtl/sr_reg_bank_pkg.sv
// Shared definitions for the SR register bank: s=r=1 resolution modes and
// the per-channel next-state function.
package sr_reg_bank_pkg;

   localparam int unsigned RESET_DOM = 32'd0;
   localparam int unsigned SET_DOM   = 32'd1;
   localparam int unsigned TOGGLE    = 32'd2;
   localparam int unsigned HOLD      = 32'd3;

   // Next value of one channel; a disabled channel holds regardless of s/r.
   function automatic logic sr_next(input int unsigned mode, input logic q,
                                    input logic e, input logic s, input logic r);
      logic nxt;
      nxt = q;
      if (e) begin
         case ({s, r})
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11: begin
               case (mode)
                  RESET_DOM: nxt = 1'b0;
                  SET_DOM:   nxt = 1'b1;
                  TOGGLE:    nxt = ~q;
                  default:   nxt = q;
               endcase
            end
            default: nxt = q;
         endcase
      end else begin
         nxt = q;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sr_reg_bank_cell.sv
// One clocked SR storage channel with a registered change pulse.
module sr_cell
   import sr_reg_bank_pkg::*;
#(
   parameter int unsigned MODE = RESET_DOM
) (
   input  logic clk,
   input  logic rst,
   input  logic e,
   input  logic s,
   input  logic r,
   output logic q,
   output logic chg
);

   logic q_r;
   logic chg_r;
   logic q_nxt_s;

   // Resolve the requested next state for this channel.
   always_comb begin
      q_nxt_s = sr_next(MODE, q_r, e, s, r);
   end

   // State and change-pulse registers; reset does not produce a change pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r   <= 1'b0;
         chg_r <= 1'b0;
      end else begin
         q_r   <= q_nxt_s;
         chg_r <= q_nxt_s ^ q_r;
      end
   end

   assign q   = q_r;
   assign chg = chg_r;

endmodule

// File: rtl/sr_reg_bank.sv
// WIDTH-channel clocked SR register bank with collision flag and saturating
// collision counter.
module sr_reg_bank
   import sr_reg_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = RESET_DOM,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             e,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] chg,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   if (MODE > HOLD) begin : g_bad_mode
      $error("sr_reg_bank: MODE must be 0..3");
   end

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] chg_s;
   logic             collision_s;
   logic             err_r;
   logic [CNT_W-1:0] cnt_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(.MODE(MODE)) u_cell (
         .clk (clk),
         .rst (rst),
         .e   (e),
         .s   (s[i]),
         .r   (r[i]),
         .q   (q_s[i]),
         .chg (chg_s[i])
      );
   end

   // Any number of simultaneous s=r=1 bits is a single collision event.
   always_comb begin
      collision_s = e & (|(s & r));
   end

   // Sticky flag and saturating counter; a clear takes effect before a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
         cnt_r <= '0;
      end else if (clr_err) begin
         err_r <= collision_s;
         cnt_r <= collision_s ? CNT_ONE : {CNT_W{1'b0}};
      end else if (collision_s) begin
         err_r <= 1'b1;
         if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         err_r <= err_r;
         cnt_r <= cnt_r;
      end
   end

   assign q       = q_s;
   assign q_n     = ~q_s;
   assign chg     = chg_s;
   assign err     = err_r;
   assign err_cnt = cnt_r;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: four banks, one per MODE, driven by the same stimulus.
module tb_sr_reg_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       e;
   logic [7:0] s;
   logic [7:0] r;
   logic       clr_err;

   logic [7:0] q_a   [4];
   logic [7:0] qn_a  [4];
   logic [7:0] chg_a [4];
   logic       err_a [4];
   logic [3:0] cnt_a [4];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      sr_reg_bank #(.WIDTH(8), .MODE(m), .CNT_W(4)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .e       (e),
         .s       (s),
         .r       (r),
         .clr_err (clr_err),
         .q       (q_a[m]),
         .q_n     (qn_a[m]),
         .chg     (chg_a[m]),
         .err     (err_a[m]),
         .err_cnt (cnt_a[m])
      );
   end

   task automatic chk(input string tag, input int m, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s mode=%0d observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   task automatic drive(input logic rst_v, input logic e_v, input logic [7:0] s_v,
                        input logic [7:0] r_v, input logic clr_v);
      rst = rst_v; e = e_v; s = s_v; r = r_v; clr_err = clr_v;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q   [4];
   logic [7:0] exp_chg [4];

   initial begin
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int m = 0; m < 4; m++) begin
         chk("rst_q", m, q_a[m], 8'h00);
         chk("rst_qn", m, qn_a[m], 8'hFF);
         chk("rst_chg", m, chg_a[m], 8'h00);
         chk("rst_err", m, err_a[m], 1'b0);
         chk("rst_cnt", m, cnt_a[m], 4'd0);
      end

      drive(1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
      for (int m = 0; m < 4; m++) begin
         chk("set_q", m, q_a[m], 8'h0F);
         chk("set_qn", m, qn_a[m], 8'hF0);
         chk("set_chg", m, chg_a[m], 8'h0F);
      end
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      chk("hold_chg", 0, chg_a[0], 8'h00);
      chk("hold_q", 0, q_a[0], 8'h0F);

      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
         for (int m = 0; m < 4; m++) begin
            chk("dis_q", m, q_a[m], 8'h0F);
            chk("dis_chg", m, chg_a[m], 8'h00);
            chk("dis_err", m, err_a[m], 1'b0);
            chk("dis_cnt", m, cnt_a[m], 4'd0);
         end
      end

      drive(1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0);
      chk("load_q", 2, q_a[2], 8'hA5);
      chk("load_chg", 2, chg_a[2], 8'hAA);

      drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      exp_q   = '{8'hA4, 8'hA5, 8'hA4, 8'hA5};
      exp_chg = '{8'h01, 8'h00, 8'h01, 8'h00};
      for (int m = 0; m < 4; m++) begin
         chk("coll_q", m, q_a[m], exp_q[m]);
         chk("coll_chg", m, chg_a[m], exp_chg[m]);
         chk("coll_err", m, err_a[m], 1'b1);
         chk("coll_cnt", m, cnt_a[m], 4'd1);
      end

      for (int n = 2; n <= 20; n++) begin
         drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
         chk("sat_cnt", 0, cnt_a[0], (n > 15) ? 32'd15 : n);
      end
      chk("sat_err", 0, err_a[0], 1'b1);
      chk("sat_tog_q", 2, q_a[2], 8'hA5);

      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      chk("clr_err", 0, err_a[0], 1'b0);
      chk("clr_cnt", 0, cnt_a[0], 4'd0);
      drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b1);
      chk("clrc_err", 0, err_a[0], 1'b1);
      chk("clrc_cnt", 0, cnt_a[0], 4'd1);

      drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
      chk("pre_q", 0, q_a[0], 8'hFF);
      drive(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
      chk("mrst_q", 0, q_a[0], 8'h00);
      chk("mrst_chg", 0, chg_a[0], 8'h00);
      chk("mrst_err", 0, err_a[0], 1'b0);
      chk("mrst_cnt", 0, cnt_a[0], 4'd0);
      drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
      chk("post_q", 0, q_a[0], 8'hFF);
      chk("post_chg", 0, chg_a[0], 8'hFF);

      drive(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
      chk("zero_q", 2, q_a[2], 8'h00);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
         chk("tog_q", 2, q_a[2], (k % 2 == 1) ? 32'h80 : 32'h00);
         chk("tog_chg", 2, chg_a[2], 8'h80);
         chk("tog_cnt", 2, cnt_a[2], k);
         chk("tog_m0_q", 0, q_a[0], 8'h00);
         chk("tog_m1_chg", 1, chg_a[1], (k == 1) ? 32'h80 : 32'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
